// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-line transmitter.
package sd_cmd_pkg;

  localparam int unsigned FRAME_BITS   = 48;
  localparam int unsigned PAYLOAD_BITS = 40;
  localparam int unsigned CRC_BITS     = 7;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned ARG_W        = 32;
  localparam int unsigned CNT_W        = 6;

  localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;
  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_GAP
  } state_e;

  // One serial step of x^7 + x^3 + 1, MSB-first feed.
  function automatic logic [CRC_BITS-1:0] crc7_step(input logic [CRC_BITS-1:0] crc,
                                                    input logic din);
    logic inv;
    inv = din ^ crc[CRC_BITS-1];
    return {crc[CRC_BITS-2:0], 1'b0} ^ (inv ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 engine on the system clock; CLR wins over EN.
module sd_crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                CLR,
  input  logic                BIT,
  output logic [CRC_BITS-1:0] CRC
);

  logic [CRC_BITS-1:0] crc_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      crc_q <= '0;
    end else if (CLR) begin
      crc_q <= '0;
    end else if (EN) begin
      crc_q <= crc7_step(crc_q, BIT);
    end
  end

  assign CRC = crc_q;

endmodule

// File: rtl/sd_cmd_tx_ctrl.sv
// Serialises one 48-bit SD command frame onto the CMD pad, paced by BIT_TICK,
// followed by GAP_BITS idle bit times before READY returns.
module sd_cmd_tx_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int unsigned GAP_BITS = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BIT_TICK,
  input  logic                START,
  input  logic [IDX_W-1:0]    CMD_IDX,
  input  logic [ARG_W-1:0]    CMD_ARG,
  output logic                READY,
  output logic                CMD_OUT,
  output logic                CMD_OE,
  output logic                DONE,
  output logic [CRC_BITS-1:0] CRC_OUT
);

  // A zero-length gap still needs one tick to release the pad after the end bit.
  localparam int unsigned GAP_LOAD = (GAP_BITS == 0) ? 0 : GAP_BITS - 1;

  state_e                  state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    out_q, out_d;
  logic                    oe_q, oe_d;
  logic                    done_q, done_d;
  logic [CRC_BITS-1:0]     crc_out_q, crc_out_d;

  logic                    crc_clr_c;
  logic                    crc_en_c;
  logic [CRC_BITS-1:0]     crc_w;
  logic [CRC_BITS:0]       crc_ext_c;

  sd_crc7_serial u_crc (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (crc_en_c),
    .CLR   (crc_clr_c),
    .BIT   (shift_q[PAYLOAD_BITS-1]),
    .CRC   (crc_w)
  );

  assign crc_ext_c = {1'b0, crc_w};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      crc_out_q <= crc_out_d;
    end
  end

  // Each state describes what the next BIT_TICK puts on the line.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    out_d     = out_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    crc_out_d = crc_out_q;
    crc_clr_c = 1'b0;
    crc_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          shift_d   = {START_BIT, TX_BIT, CMD_IDX, CMD_ARG};
          cnt_d     = '0;
          crc_clr_c = 1'b1;
          ready_d   = 1'b0;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (BIT_TICK) begin
          oe_d     = 1'b1;
          out_d    = shift_q[PAYLOAD_BITS-1];
          shift_d  = {shift_q[PAYLOAD_BITS-2:0], 1'b0};
          crc_en_c = 1'b1;
          cnt_d    = CNT_W'(PAYLOAD_BITS - 2);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (BIT_TICK) begin
          out_d    = shift_q[PAYLOAD_BITS-1];
          shift_d  = {shift_q[PAYLOAD_BITS-2:0], 1'b0};
          crc_en_c = 1'b1;
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(CRC_BITS - 1);
            state_d = ST_CRC;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_CRC: begin
        if (BIT_TICK) begin
          out_d = crc_ext_c[cnt_q[2:0]];
          if (cnt_q == '0) begin
            state_d = ST_END;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_END: begin
        if (BIT_TICK) begin
          out_d     = END_BIT;
          crc_out_d = crc_w;
          cnt_d     = CNT_W'(GAP_LOAD);
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (BIT_TICK) begin
          oe_d  = 1'b0;
          out_d = 1'b1;
          if (cnt_q == '0) begin
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign READY   = ready_q;
  assign CMD_OUT = out_q;
  assign CMD_OE  = oe_q;
  assign DONE    = done_q;
  assign CRC_OUT = crc_out_q;

endmodule
